// File: rtl/booth_pp_accum.sv
// Two-stage radix-8 Booth partial-product accumulator with valid/ready handshake.
// S1 registers the digit selects and the precomputed multiples 1B..7B of the
// multiplicand; S2 sums the selected multiples and applies the sign.
module booth_pp_accum #(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned OBOOTHSEL_WIDTH = 7,
    parameter int unsigned PROD_WIDTH      = 16
) (
    input  logic                                iClk,
    input  logic                                iRst,
    input  logic                                iValid,
    output logic                                oReady,
    input  logic [1:0][OBOOTHSEL_WIDTH-1:0]     iBoothSel,
    input  logic                                iHighBit,
    input  logic                                iNegative,
    input  logic [DATA_WIDTH-1:0]               iMcand,
    output logic                                oValid,
    input  logic                                iReady,
    output logic [PROD_WIDTH-1:0]               oProd,
    output logic                                oSelErr
);

    localparam int unsigned MULT_WIDTH = DATA_WIDTH + 3;
    localparam int unsigned GUARD_BITS = MULT_WIDTH - DATA_WIDTH;
    localparam int unsigned EXT_WIDTH  = PROD_WIDTH - MULT_WIDTH;
    localparam int unsigned NUM_MULT   = OBOOTHSEL_WIDTH;

    typedef struct packed {
        logic [1:0][OBOOTHSEL_WIDTH-1:0]  boothSel;
        logic                             highBit;
        logic                             negative;
        logic [NUM_MULT-1:0][MULT_WIDTH-1:0] mult;
    } s1Entry_t;

    s1Entry_t               s1Next;
    s1Entry_t               s1Entry;
    logic                   s1Valid;
    logic                   s1Adv;
    logic                   s2Adv;
    logic                   inXfer;
    logic [PROD_WIDTH-1:0]  prodNext;
    logic                   selErrNext;

    // Handshake: S2 moves when empty or drained, S1 follows S2.
    assign s2Adv  = !oValid || iReady;
    assign s1Adv  = !s1Valid || s2Adv;
    assign oReady = s1Adv;
    assign inXfer = iValid && oReady;

    // Build the S1 payload: raw selects plus sign-extended multiples 1B..7B.
    always_comb begin
        logic [MULT_WIDTH-1:0] b1;
        logic [MULT_WIDTH-1:0] b2;
        logic [MULT_WIDTH-1:0] b3;
        logic [MULT_WIDTH-1:0] b4;
        logic [MULT_WIDTH-1:0] b8;
        s1Next          = '0;
        b1              = {{GUARD_BITS{iMcand[DATA_WIDTH-1]}}, iMcand};
        b2              = b1 << 1;
        b3              = b2 + b1;
        b4              = b1 << 2;
        b8              = b1 << 3;
        s1Next.boothSel = iBoothSel;
        s1Next.highBit  = iHighBit;
        s1Next.negative = iNegative;
        s1Next.mult[0]  = b1;
        s1Next.mult[1]  = b2;
        s1Next.mult[2]  = b3;
        s1Next.mult[3]  = b4;
        s1Next.mult[4]  = b4 + b1;
        s1Next.mult[5]  = b3 << 1;
        s1Next.mult[6]  = b8 - b1;
    end

    // Stage S1 register.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            s1Valid <= 1'b0;
            s1Entry <= '0;
        end else begin
            if (s1Adv) begin
                s1Valid <= iValid;
            end
            if (inXfer) begin
                s1Entry <= s1Next;
            end
        end
    end

    // Select and sum the partial products held in S1, then apply the sign.
    always_comb begin
        logic [1:0][MULT_WIDTH-1:0] pick;
        logic [PROD_WIDTH-1:0]      termLo;
        logic [PROD_WIDTH-1:0]      termMid;
        logic [PROD_WIDTH-1:0]      termHi;
        logic [PROD_WIDTH-1:0]      termWrap;
        logic [PROD_WIDTH-1:0]      bFull;
        logic [PROD_WIDTH-1:0]      sum;
        logic                       wrap;
        pick       = '0;
        selErrNext = 1'b0;
        for (int unsigned k = 0; k < 2; k++) begin
            for (int unsigned i = 0; i < NUM_MULT; i++) begin
                if (s1Entry.boothSel[k][i]) begin
                    pick[k] = pick[k] | s1Entry.mult[i];
                end
            end
            // More than one bit set: x & (x-1) keeps everything but the lowest set bit.
            if ((s1Entry.boothSel[k] & (s1Entry.boothSel[k] - OBOOTHSEL_WIDTH'(1))) != '0) begin
                selErrNext = 1'b1;
            end
        end
        // All-zero magnitude with the sign set encodes A = -128.
        wrap     = s1Entry.negative && !s1Entry.highBit && (s1Entry.boothSel == '0);
        bFull    = {{EXT_WIDTH{s1Entry.mult[0][MULT_WIDTH-1]}}, s1Entry.mult[0]};
        termLo   = {{EXT_WIDTH{pick[0][MULT_WIDTH-1]}}, pick[0]};
        termMid  = {{EXT_WIDTH{pick[1][MULT_WIDTH-1]}}, pick[1]} << 3;
        termHi   = s1Entry.highBit ? (bFull << 6) : '0;
        termWrap = wrap ? (bFull << 7) : '0;
        sum      = termLo + termMid + termHi + termWrap;
        if (selErrNext) begin
            prodNext = '0;
        end else if (s1Entry.negative) begin
            prodNext = -sum;
        end else begin
            prodNext = sum;
        end
    end

    // Stage S2 register drives the outputs directly; it holds while stalled.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            oValid  <= 1'b0;
            oProd   <= '0;
            oSelErr <= 1'b0;
        end else if (s2Adv) begin
            oValid <= s1Valid;
            if (s1Valid) begin
                oProd   <= prodNext;
                oSelErr <= selErrNext;
            end
        end
    end

endmodule

// File: tb/tb_booth_pp_accum.sv
// Directed bench for booth_pp_accum: hand-computed products, stall and reset cases.
module tb_booth_pp_accum;

    logic            iClk = 1'b0;
    logic            iRst;
    logic            iValid;
    logic            oReady;
    logic [1:0][6:0] iBoothSel;
    logic            iHighBit;
    logic            iNegative;
    logic [7:0]      iMcand;
    logic            oValid;
    logic            iReady;
    logic [15:0]     oProd;
    logic            oSelErr;

    int errCount   = 0;
    int checkCount = 0;

    always #5 iClk = ~iClk;

    booth_pp_accum dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iValid    (iValid),
        .oReady    (oReady),
        .iBoothSel (iBoothSel),
        .iHighBit  (iHighBit),
        .iNegative (iNegative),
        .iMcand    (iMcand),
        .oValid    (oValid),
        .iReady    (iReady),
        .oProd     (oProd),
        .oSelErr   (oSelErr)
    );

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] expVal);
        checkCount++;
        if (got !== expVal) begin
            errCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expVal);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic drive(input logic [6:0] sel0, input logic [6:0] sel1,
                         input logic hb, input logic neg, input logic [7:0] b);
        iBoothSel[0] = sel0;
        iBoothSel[1] = sel1;
        iHighBit     = hb;
        iNegative    = neg;
        iMcand       = b;
    endtask

    // One isolated transfer with iReady held high: checks latency 2 and result.
    task automatic runOne(input string tag, input logic [6:0] sel0, input logic [6:0] sel1,
                          input logic hb, input logic neg, input logic [7:0] b,
                          input logic [15:0] expProd, input logic expErr);
        iReady = 1'b1;
        drive(sel0, sel1, hb, neg, b);
        iValid = 1'b1;
        #1;
        checkEq({tag, ".ready"}, 32'(oReady), 32'd1);
        tick();
        iValid = 1'b0;
        #1;
        checkEq({tag, ".lat1"}, 32'(oValid), 32'd0);
        tick();
        #1;
        checkEq({tag, ".valid"}, 32'(oValid), 32'd1);
        checkEq({tag, ".prod"}, 32'(oProd), 32'(expProd));
        checkEq({tag, ".selErr"}, 32'(oSelErr), 32'(expErr));
        tick();
        #1;
        checkEq({tag, ".drop"}, 32'(oValid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        iRst   = 1'b1;
        iValid = 1'b0;
        iReady = 1'b1;
        drive(7'd0, 7'd0, 1'b0, 1'b0, 8'd0);

        // Reset state
        tick();
        tick();
        #1;
        checkEq("rst.oValid", 32'(oValid), 32'd0);
        checkEq("rst.oProd", 32'(oProd), 32'h0);
        checkEq("rst.oSelErr", 32'(oSelErr), 32'd0);
        iRst = 1'b0;
        tick();
        #1;
        checkEq("rst.oReady", 32'(oReady), 32'd1);

        // Directed products
        runOne("5x3",      7'b001_0000, 7'b000_0000, 1'b0, 1'b0, 8'd3,   16'h000F, 1'b0);
        runOne("100xm7",   7'b000_1000, 7'b000_1000, 1'b1, 1'b0, 8'hF9,  16'hFD44, 1'b0);
        runOne("m128xm128",7'b000_0000, 7'b000_0000, 1'b0, 1'b1, 8'h80,  16'h4000, 1'b0);
        runOne("m128x1",   7'b000_0000, 7'b000_0000, 1'b0, 1'b1, 8'h01,  16'hFF80, 1'b0);
        runOne("m1x127",   7'b000_0001, 7'b000_0000, 1'b0, 1'b1, 8'h7F,  16'hFF81, 1'b0);
        runOne("err0",     7'b000_0011, 7'b000_0000, 1'b0, 1'b1, 8'h7F,  16'h0000, 1'b1);
        runOne("err1",     7'b000_0000, 7'b100_0001, 1'b0, 1'b0, 8'h05,  16'h0000, 1'b1);
        runOne("127xm128", 7'b100_0000, 7'b100_0000, 1'b1, 1'b0, 8'h80,  16'hC080, 1'b0);
        runOne("m100xm7",  7'b000_1000, 7'b000_1000, 1'b1, 1'b1, 8'hF9,  16'h02BC, 1'b0);
        runOne("0x55",     7'b000_0000, 7'b000_0000, 1'b0, 1'b0, 8'd55,  16'h0000, 1'b0);

        // Back-to-back 1*1, 2*2, 3*3 with iReady low for four cycles
        iReady = 1'b0;
        drive(7'b000_0001, 7'd0, 1'b0, 1'b0, 8'd1);
        iValid = 1'b1;
        #1;
        checkEq("stall.rdy0", 32'(oReady), 32'd1);
        tick();
        drive(7'b000_0010, 7'd0, 1'b0, 1'b0, 8'd2);
        #1;
        checkEq("stall.rdy1", 32'(oReady), 32'd1);
        tick();
        drive(7'b000_0100, 7'd0, 1'b0, 1'b0, 8'd3);
        #1;
        checkEq("stall.rdyLow", 32'(oReady), 32'd0);
        checkEq("stall.valid", 32'(oValid), 32'd1);
        checkEq("stall.hold0", 32'(oProd), 32'h0001);
        tick();
        #1;
        checkEq("stall.rdyLow2", 32'(oReady), 32'd0);
        checkEq("stall.hold1", 32'(oProd), 32'h0001);
        checkEq("stall.validHold", 32'(oValid), 32'd1);
        tick();
        iReady = 1'b1;
        #1;
        checkEq("stall.rdyRelease", 32'(oReady), 32'd1);
        checkEq("stall.out1", 32'(oProd), 32'h0001);
        tick();
        iValid = 1'b0;
        #1;
        checkEq("stall.valid4", 32'(oValid), 32'd1);
        checkEq("stall.out4", 32'(oProd), 32'h0004);
        tick();
        #1;
        checkEq("stall.valid9", 32'(oValid), 32'd1);
        checkEq("stall.out9", 32'(oProd), 32'h0009);
        tick();
        #1;
        checkEq("stall.drain", 32'(oValid), 32'd0);

        // Reset with both stages full
        iReady = 1'b0;
        drive(7'b000_1000, 7'd0, 1'b0, 1'b0, 8'd4);
        iValid = 1'b1;
        tick();
        drive(7'b001_0000, 7'd0, 1'b0, 1'b0, 8'd5);
        tick();
        iValid = 1'b0;
        #1;
        checkEq("mid.full", 32'(oValid), 32'd1);
        checkEq("mid.prod16", 32'(oProd), 32'h0010);
        checkEq("mid.s1Full", 32'(oReady), 32'd0);
        iRst = 1'b1;
        tick();
        #1;
        checkEq("mid.rstValid", 32'(oValid), 32'd0);
        checkEq("mid.rstProd", 32'(oProd), 32'h0);
        iRst   = 1'b0;
        iReady = 1'b1;
        #1;
        checkEq("mid.rstReady", 32'(oReady), 32'd1);
        for (int n = 0; n < 3; n++) begin
            tick();
            #1;
            checkEq("mid.noStale", 32'(oValid), 32'd0);
        end
        runOne("post2x3", 7'b000_0010, 7'd0, 1'b0, 1'b0, 8'd3, 16'h0006, 1'b0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/booth_pp_accum.md
BOOTH_PP_ACCUM -- requirements
Module: booth_pp_accum

Interface
REQ-001 Parameter DATA_WIDTH, default 8: multiplier and multiplicand width; only 8 supported.
REQ-002 Parameter OBOOTHSEL_WIDTH, default 7: one-hot select width per radix-8 digit (multiples 1x..7x).
REQ-003 Parameter PROD_WIDTH, default 16: signed product width.
REQ-004 Ports (name, direction, width, meaning):
- iClk  in  1  single clock, all state updates on rising edge.
- iRst  in  1  reset, synchronous, active-high.
- iValid  in  1  upstream encode word and multiplicand valid.
- oReady  out  1  block accepts input this cycle.
- iBoothSel  in  [1:0][6:0]  one-hot digit selects; [0] = magnitude bits 2:0, [1] = bits 5:3; all-zero = digit 0.
- iHighBit  in  1  magnitude bit 6 (weight 64).
- iNegative  in  1  multiplier sign.
- iMcand  in  8  signed multiplicand B.
- oValid  out  1  product valid.
- iReady  in  1  downstream accepts product.
- oProd  out  16  signed product A*B.
- oSelErr  out  1  the accepted select word was malformed; qualified by oValid.

Function
REQ-005 An input transfer occurs when iValid and oReady are both high in the same cycle; an output transfer occurs when oValid and iReady are both high in the same cycle.
REQ-006 Two register stages, S1 and S2, each with its own valid bit:
- Latency is exactly 2 cycles from input transfer to oValid when iReady is held high.
- Throughput is 1 result per cycle.
REQ-007 S1 captures the following on an input transfer:
- iBoothSel, iHighBit, iNegative.
- Sign-extended 11-bit multiples 1B..7B of iMcand, computed before the register.
REQ-008 S2 advances when S2 is empty or an output transfer occurs; S1 advances when S1 is empty or S2 advances.
REQ-009 oReady = !S1.valid OR S2 advances; the combinational ready path from iReady to oReady is permitted.
REQ-010 While oValid is high and iReady is low, oProd, oSelErr and oValid hold stable.
REQ-011 Transfers complete in order; no transfer is lost or duplicated under any iValid/iReady pattern.
REQ-012 Magnitude M:
- M = 64*iHighBit + 8*d1 + d0, where dk = index+1 of the set bit in iBoothSel[k], or 0 if that select is all-zero.
- Special case: iNegative=1 with both selects all-zero and iHighBit=0 means M = 128 (the A = -128 wrap).
REQ-013 S2 product:
- P = (sel0 multiple) + (sel1 multiple << 3) + (iHighBit ? B<<6 : 0), plus B<<7 in the M = 128 case.
- All terms are sign-extended to 16 bits.
- oProd = iNegative ? -P : P, registered in S2.
REQ-014 Arithmetic is exact two's complement in 16 bits; the extreme case (-128)*(-128) = +16384 (0x4000) does not overflow.
REQ-015 oSelErr = 1 when either iBoothSel[k] has more than one bit set; in that case oProd = 0x0000 and the transfer still completes normally.
REQ-016 A valid-qualified S1 or S2 entry with iNegative=1 and M=0 cannot exist; the only all-zero encoding with iNegative=1 is treated per REQ-012.

Reset
REQ-017 While iRst is high at a clock edge:
- S1.valid and S2.valid clear to 0.
- oValid = 0, oProd = 0x0000, oSelErr = 0.
REQ-018 oReady is 1 in the first cycle after iRst deasserts.
REQ-019 Reset asserted mid-operation discards all in-flight entries; no oValid pulse follows for them.
REQ-020 The datapath registers other than the valid bits also reset to 0.

Verification
REQ-021 A=5 (sel0=7'b001_0000, sel1=0, HB=0, Neg=0), B=3, iReady=1 -> 2 cycles later oValid=1, oProd=0x000F, oSelErr=0.
REQ-022 A=100 (sel0=7'b000_1000, sel1=7'b000_1000, HB=1, Neg=0), B=-7 -> oProd=0xFD44 (-700).
REQ-023 A=-128 (selects 0, HB=0, Neg=1), B=-128 -> oProd=0x4000; same encoding with B=1 -> oProd=0xFF80.
REQ-024 A=-1 (sel0=7'b000_0001, Neg=1), B=127 -> oProd=0xFF81; sel0=7'b000_0011 -> oSelErr=1, oProd=0x0000.
REQ-025 Back-to-back inputs 1*1, 2*2, 3*3 with iReady low for 4 cycles:
- oReady falls after 2 accepts.
- oProd holds 0x0001 while stalled.
- On release, outputs 1, 4, 9 follow in order on consecutive cycles.
REQ-026 Reset pulse with both stages full -> oValid=0 next cycle; no stale results appear afterward; a fresh 2*3 afterwards gives 0x0006 at latency 2.
